// File: rtl/gray_pkg.sv
`default_nettype none
// =============================================================================
// Module   : gray_pkg
// Brief    : Shared types, defaults and Gray-to-binary helper for the tracker.
// Revision : 1.0 - initial release
// =============================================================================
package gray_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_ERROR   = 2'd2
    } state_t;

    localparam int c_DEF_WIDTH      = 4;
    localparam int c_DEF_STABLE_CYC = 3;
    localparam int c_DEF_POS_W      = 16;
    localparam int c_GRAY_MAX_W     = 32;

    // MSB-down XOR prefix; bits at or above width are treated as absent.
    function automatic logic [c_GRAY_MAX_W-1:0] gray2bin(
        input logic [c_GRAY_MAX_W-1:0] gray,
        input int                      width
    );
        logic [c_GRAY_MAX_W-1:0] bin;
        logic                    acc;
        bin = '0;
        acc = 1'b0;
        for (int i = c_GRAY_MAX_W - 1; i >= 0; i--) begin
            if (i < width) begin
                acc    = acc ^ gray[i];
                bin[i] = acc;
            end
        end
        return bin;
    endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_debounce.sv
`default_nettype none
// =============================================================================
// Module   : gray_debounce
// Brief    : Candidate register and saturating match counter; strobes accept
//            on the sample that completes STABLE_CYC identical valid samples.
// Revision : 1.0 - initial release
// =============================================================================
module gray_debounce
    import gray_pkg::*;
#(
    parameter int WIDTH      = c_DEF_WIDTH,
    parameter int STABLE_CYC = c_DEF_STABLE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic             accept
);

    localparam int               c_CNT_W = $clog2(STABLE_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_SAT  = c_CNT_W'(STABLE_CYC);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(STABLE_CYC - 1);

    logic [WIDTH-1:0]   r_cand;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_match;
    logic               w_reload_accept;

    assign w_match = (gray_in == r_cand);

    // With a single-sample window a freshly reloaded code is already stable.
    generate
        if (STABLE_CYC == 1) begin : g_single
            assign w_reload_accept = 1'b1;
        end else begin : g_multi
            assign w_reload_accept = 1'b0;
        end
    endgenerate

    assign accept = in_valid && (w_match ? (r_cnt == c_LAST) : w_reload_accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (in_valid) begin
            if (w_match) begin
                if (r_cnt != c_SAT) begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end else begin
                r_cand <= gray_in;
                r_cnt  <= c_CNT_W'(1);
            end
        end
    end

endmodule : gray_debounce
`default_nettype wire

// File: rtl/gray_position_tracker.sv
`default_nettype none
// =============================================================================
// Module   : gray_position_tracker
// Brief    : Debounced Gray encoder tracker with legal-step checking, position
//            accumulator, direction/step strobes and sticky jump error.
// Revision : 1.0 - initial release
// =============================================================================
module gray_position_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH      = c_DEF_WIDTH,
    parameter int STABLE_CYC = c_DEF_STABLE_CYC,
    parameter int POS_W      = c_DEF_POS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] bin_out,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             step_pulse,
    output logic             err,
    output logic             locked
);

    localparam logic [WIDTH-1:0] c_DELTA_UP = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_DELTA_DN = {WIDTH{1'b1}};

    state_t           r_state;
    logic [WIDTH-1:0] r_bin;
    logic [POS_W-1:0] r_pos;
    logic             r_dir;
    logic             r_step;
    logic             r_err;
    logic             r_locked;

    logic             w_accept;
    logic [WIDTH-1:0] w_new_bin;
    logic [WIDTH-1:0] w_delta;

    gray_debounce #(
        .WIDTH      (WIDTH),
        .STABLE_CYC (STABLE_CYC)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .gray_in  (gray_in),
        .in_valid (in_valid),
        .accept   (w_accept)
    );

    assign w_new_bin = WIDTH'(gray2bin(c_GRAY_MAX_W'(gray_in), WIDTH));
    // Modular difference makes the code wrap a legal single step both ways.
    assign w_delta   = w_new_bin - r_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ACQUIRE;
            r_bin    <= '0;
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_step   <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (clear) begin
                r_state  <= ST_ACQUIRE;
                r_err    <= 1'b0;
                r_pos    <= '0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_ACQUIRE: begin
                        if (w_accept) begin
                            r_bin    <= w_new_bin;
                            r_pos    <= '0;
                            r_state  <= ST_TRACK;
                            r_locked <= 1'b1;
                        end
                    end
                    ST_TRACK: begin
                        if (w_accept) begin
                            if (w_delta == c_DELTA_UP) begin
                                r_bin  <= w_new_bin;
                                r_pos  <= r_pos + POS_W'(1);
                                r_dir  <= 1'b1;
                                r_step <= 1'b1;
                            end else if (w_delta == c_DELTA_DN) begin
                                r_bin  <= w_new_bin;
                                r_pos  <= r_pos - POS_W'(1);
                                r_dir  <= 1'b0;
                                r_step <= 1'b1;
                            end else begin
                                r_err    <= 1'b1;
                                r_state  <= ST_ERROR;
                                r_locked <= 1'b0;
                            end
                        end
                    end
                    ST_ERROR: begin
                        r_state <= ST_ERROR;
                    end
                    default: begin
                        r_state  <= ST_ACQUIRE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bin_out    = r_bin;
    assign pos        = r_pos;
    assign dir        = r_dir;
    assign step_pulse = r_step;
    assign err        = r_err;
    assign locked     = r_locked;

endmodule : gray_position_tracker
`default_nettype wire
